// File: rtl/car_sensor_emulator.sv
// car_sensor_emulator: plays out four-phase A/B gate-sensor waveforms
// (entry or exit) on active-low lines for parking-lot self-test.
module car_sensor_emulator #(
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_in,
  input  logic       start_out,
  input  logic       abort,
  output logic       a_btn,
  output logic       b_btn,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       dir,
  output logic [7:0] seq_count
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_aborted;
  logic             r_a_btn;
  logic             r_b_btn;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_seq_count;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_zero;
  logic             w_in_phase;
  logic             w_dir_next;
  logic             w_aborted_next;
  logic             w_a_act;
  logic             w_b_act;
  logic             w_ready_next;
  logic             w_done_next;
  logic             w_err_next;
  logic [7:0]       w_seq_next;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_in_phase = (r_state == S_P1) || (r_state == S_P2) || (r_state == S_P3);

  // State, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dir       <= 1'b1;
      r_aborted   <= 1'b0;
      r_a_btn     <= 1'b1;
      r_b_btn     <= 1'b1;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_seq_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_dir       <= w_dir_next;
      r_aborted   <= w_aborted_next;
      r_a_btn     <= ~w_a_act;
      r_b_btn     <= ~w_b_act;
      r_ready     <= w_ready_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_seq_count <= w_seq_next;
    end
  end

  // Next state; abort outranks phase timeout; counter reloads on every state entry
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start_in ^ start_out) w_state_next = S_P1;
      S_P1: begin
        if (abort)           w_state_next = S_GAP;
        else if (w_cnt_zero) w_state_next = S_P2;
      end
      S_P2: begin
        if (abort)           w_state_next = S_GAP;
        else if (w_cnt_zero) w_state_next = S_P3;
      end
      S_P3: begin
        if (abort || w_cnt_zero) w_state_next = S_GAP;
      end
      S_GAP:   if (w_cnt_zero) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_cnt_next = w_cnt_zero ? '0 : (r_cnt - CNT_W'(1));
    if (w_state_next != r_state) begin
      case (w_state_next)
        S_P1, S_P2, S_P3: w_cnt_next = HOLD_LOAD;
        S_GAP:            w_cnt_next = GAP_LOAD;
        default:          w_cnt_next = '0;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    w_dir_next     = r_dir;
    w_err_next     = 1'b0;
    w_aborted_next = r_aborted;
    w_a_act        = 1'b0;
    w_b_act        = 1'b0;

    if (r_state == S_IDLE) begin
      w_aborted_next = 1'b0;
      if (start_in && start_out) w_err_next = 1'b1;
      else if (start_in)         w_dir_next = 1'b1;
      else if (start_out)        w_dir_next = 1'b0;
    end else if (w_in_phase && abort) begin
      w_aborted_next = 1'b1;
    end

    w_done_next  = (r_state == S_GAP) && w_cnt_zero && !r_aborted;
    w_seq_next   = w_done_next ? (r_seq_count + 8'd1) : r_seq_count;
    w_ready_next = (w_state_next == S_IDLE);

    // Entry: A, AB, B; exit: B, AB, A. One line changes per boundary.
    case (w_state_next)
      S_P1: begin
        w_a_act = w_dir_next;
        w_b_act = ~w_dir_next;
      end
      S_P2: begin
        w_a_act = 1'b1;
        w_b_act = 1'b1;
      end
      S_P3: begin
        w_a_act = ~w_dir_next;
        w_b_act = w_dir_next;
      end
      default: begin
        w_a_act = 1'b0;
        w_b_act = 1'b0;
      end
    endcase
  end

  assign a_btn     = r_a_btn;
  assign b_btn     = r_b_btn;
  assign ready     = r_ready;
  assign done      = r_done;
  assign err       = r_err;
  assign dir       = r_dir;
  assign seq_count = r_seq_count;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator with H=4, G=3. Expected per-cycle
// {a_btn,b_btn,ready,done,err} vectors are queued when stimulus is driven.
module tb_car_sensor_emulator;

  localparam int unsigned H = 4;
  localparam int unsigned G = 3;

  logic       clk;
  logic       reset;
  logic       start_in;
  logic       start_out;
  logic       abort;
  logic       a_btn;
  logic       b_btn;
  logic       ready;
  logic       done;
  logic       err;
  logic       dir;
  logic [7:0] seq_count;

  int checks;
  int errors;
  logic [4:0] exp_q[$];

  car_sensor_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .start_out (start_out),
    .abort     (abort),
    .a_btn     (a_btn),
    .b_btn     (b_btn),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .dir       (dir),
    .seq_count (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output words {a_btn, b_btn, ready, done, err}
  localparam logic [4:0] V_A    = 5'b01000;  // A pressed only
  localparam logic [4:0] V_B    = 5'b10000;  // B pressed only
  localparam logic [4:0] V_AB   = 5'b00000;
  localparam logic [4:0] V_GAP  = 5'b11000;
  localparam logic [4:0] V_IDLE = 5'b11100;
  localparam logic [4:0] V_DONE = 5'b11110;
  localparam logic [4:0] V_ERR  = 5'b11101;

  task automatic push_n(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Full normal sequence for a start sampled at the previous edge
  task automatic push_seq(input bit entry);
    push_n(entry ? V_A : V_B, H);
    push_n(V_AB, H);
    push_n(entry ? V_B : V_A, H);
    push_n(V_GAP, G);
    push_n(V_DONE, 1);
  endtask

  task automatic test_reset();
    reset = 1'b0; start_in = 1'b0; start_out = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_btn, b_btn, ready, done, err} !== V_IDLE) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {a_btn, b_btn, ready, done, err}, V_IDLE);
    end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", dir); end
    checks++;
    if (seq_count !== 8'd0) begin errors++; $display("FAIL reset_seq got %0d want 0", seq_count); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry();
    logic [4:0] e;
    int i;
    start_in = 1'b1;
    push_seq(1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL entry cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) start_in = 1'b0;
      i++;
    end
    checks++;
    if (seq_count !== 8'd1) begin errors++; $display("FAIL entry_seq got %0d want 1", seq_count); end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL entry_dir got %b want 1", dir); end
  endtask

  // Exit started in the done cycle of the previous entry
  task automatic test_back_to_back();
    logic [4:0] e;
    int i;
    start_out = 1'b1;
    push_seq(1'b0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL b2b_exit cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) start_out = 1'b0;
      i++;
    end
    checks++;
    if (seq_count !== 8'd2) begin errors++; $display("FAIL exit_seq got %0d want 2", seq_count); end
    checks++;
    if (dir !== 1'b0) begin errors++; $display("FAIL exit_dir got %b want 0", dir); end
  endtask

  task automatic test_err();
    logic [4:0] e;
    int i;
    @(negedge clk);
    start_in = 1'b1; start_out = 1'b1;
    push_n(V_ERR, 1);
    push_n(V_IDLE, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL err cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) begin start_in = 1'b0; start_out = 1'b0; end
      i++;
    end
    checks++;
    if (dir !== 1'b0) begin errors++; $display("FAIL err_dir got %b want 0", dir); end
  endtask

  task automatic test_ignored_start();
    logic [4:0] e;
    int i;
    start_in = 1'b1;
    push_seq(1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL ignored cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) start_in = 1'b0;
      if (i == 4) start_out = 1'b1;
      if (i == 5) start_out = 1'b0;
      i++;
    end
    checks++;
    if (seq_count !== 8'd3) begin errors++; $display("FAIL ignored_seq got %0d want 3", seq_count); end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL ignored_dir got %b want 1", dir); end
  endtask

  // Abort raised during the second cycle of P2
  task automatic test_abort();
    logic [4:0] e;
    int i;
    start_in = 1'b1;
    push_n(V_A, H);
    push_n(V_AB, 2);
    push_n(V_GAP, G);
    push_n(V_IDLE, 3);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL abort cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) start_in = 1'b0;
      if (i == 5) abort = 1'b1;
      if (i == 6) abort = 1'b0;
      i++;
    end
    checks++;
    if (seq_count !== 8'd3) begin errors++; $display("FAIL abort_seq got %0d want 3", seq_count); end
  endtask

  // Reset asserted in the first cycle of P3 of an exit
  task automatic test_reset_mid();
    logic [4:0] e;
    int i;
    start_out = 1'b1;
    push_n(V_B, H);
    push_n(V_AB, H);
    push_n(V_A, 1);
    push_n(V_IDLE, 12);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({a_btn, b_btn, ready, done, err} !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %b want %b", i + 1, {a_btn, b_btn, ready, done, err}, e);
      end
      if (i == 0) start_out = 1'b0;
      if (i == 8) reset = 1'b0;
      if (i == 9) begin
        reset = 1'b1;
        checks++;
        if (seq_count !== 8'd0) begin errors++; $display("FAIL reset_mid_seq got %0d want 0", seq_count); end
        checks++;
        if (dir !== 1'b1) begin errors++; $display("FAIL reset_mid_dir got %b want 1", dir); end
      end
      i++;
    end
    checks++;
    if (seq_count !== 8'd0) begin errors++; $display("FAIL reset_mid_seq_end got %0d want 0", seq_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_entry();
    test_back_to_back();
    test_err();
    test_ignored_start();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/car_sensor_emulator.md
# car_sensor_emulator

Generates the two-sensor gate waveforms a car produces when entering or leaving the parking lot. It drives active-low `a_btn`/`b_btn` lines that plug directly into the parking top level in place of the physical push-buttons, for board self-test and closed-loop simulation. Each requested car passage is played out as a four-phase sensor sequence. Every phase is held long enough to pass the debouncers.

## Interface
- `HOLD_CYCLES`, default 500000: cycles each sensor phase is held; must be ≥ 2.
- `GAP_CYCLES`, default 250000: cycles both sensors stay released after a sequence; must be ≥ 1.
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: synchronous, active-low reset.
- `start_in` input 1: request an entry sequence; sampled only in IDLE.
- `start_out` input 1: request an exit sequence; sampled only in IDLE.
- `abort` input 1: cancel the sequence in progress.
- `a_btn` output 1: emulated sensor A, active-low, idle 1.
- `b_btn` output 1: emulated sensor B, active-low, idle 1.
- `ready` output 1: high in IDLE.
- `done` output 1: one-cycle pulse when a sequence completes normally.
- `err` output 1: one-cycle pulse when `start_in` and `start_out` are both high in IDLE.
- `dir` output 1: latched direction of the current or last sequence; 1 = entry, 0 = exit.
- `seq_count` output 8: number of completed sequences.

## Operation
- **States:** IDLE, P1, P2, P3, GAP.
- **Phase counter:** width `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`; reloaded on every state entry.
- **Sensor pattern, entry (`dir`=1)** (active-high sense; outputs are the inverse):
  - P1: A only.
  - P2: A and B.
  - P3: B only.
  - GAP: none.
- **Sensor pattern, exit (`dir`=0):**
  - P1: B only.
  - P2: A and B.
  - P3: A only.
  - GAP: none.
- **IDLE:**
  - `start_in` alone: latch `dir`=1, go to P1.
  - `start_out` alone: latch `dir`=0, go to P1.
  - Both high: stay in IDLE, pulse `err`, `dir` unchanged.
- **Phase transitions:** P1→P2→P3→GAP, each after exactly `HOLD_CYCLES` cycles in the state.
- **GAP:** → IDLE after exactly `GAP_CYCLES` cycles, with `done` pulsed and `seq_count` incremented. `seq_count` wraps 255→0.
- **Starts while not IDLE:** ignored. There is no queue and no `err`.
- **`abort` in P1/P2/P3:** go directly to GAP, full `GAP_CYCLES` applied. At the end of that GAP: no `done`, no `seq_count` increment.
- **`abort` in IDLE or GAP:** no effect; a GAP entered by abort still suppresses `done`.
- **Priority:** `abort` outranks the normal phase-timeout transition when both occur in the same cycle.
- **Outputs:** `a_btn`, `b_btn`, `ready`, `done`, `err` are all registered. No combinational path from inputs to outputs.
- **Reset (`reset`=0 at a clock edge), values after that edge:**
  - State IDLE.
  - `a_btn`=1, `b_btn`=1.
  - `ready`=1, `done`=0, `err`=0.
  - `dir`=1, `seq_count`=0.
  - Counter cleared.
  - Applies mid-sequence too: lines release immediately and no `done` is issued.

## Timing
- **Start acceptance:** a start sampled high at edge k (state IDLE):
  - `ready`=0 and the P1 pattern appear after edge k.
  - P1 occupies cycles k+1 … k+H; P2 k+H+1 … k+2H; P3 k+2H+1 … k+3H; GAP k+3H+1 … k+3H+G.
  - `done`=1 and `ready`=1 in cycle k+3H+G+1.
  - `seq_count` reads the new value in that same cycle.
  - Here H = `HOLD_CYCLES`, G = `GAP_CYCLES`.
- **Back-to-back:** a start sampled in the `done` cycle is accepted. Minimum spacing between sequences is 3H+G+1 cycles.
- **`err`:** high in the cycle after the edge at which both starts were sampled.
- **`abort` sampled at edge m in P1–P3:** GAP pattern from m+1; IDLE at m+G+1 with `done`=0.
- **No glitches:** exactly one sensor line changes per phase boundary, and both are released only at P3→GAP.

## Test plan
- **Entry sequence** (H=4, G=3): reset, then `start_in` pulse. Required response:
  - (a,b) low/high pattern: (0,1)×4, (0,0)×4, (1,0)×4, (1,1)×3.
  - `done` pulse 16 cycles after the start edge; `seq_count`=1; `dir`=1.
- **Exit sequence** (H=4, G=3): `start_out`. Required response:
  - Pattern (1,0)×4, (0,0)×4, (0,1)×4, (1,1)×3.
  - `dir`=0; `seq_count` +1.
- **Loopback into the parking top** (HOLD above the debounce time): 3 entries, then 1 exit → `led_counter`=2, and `seq_count`=4.
- **Simultaneous and ignored starts:**
  - `start_in` and `start_out` high together in IDLE → `err` pulse, outputs stay (1,1), `ready` stays 1.
  - `start_out` during P2 → ignored; the entry completes normally.
- **Abort:** abort in the 2nd cycle of P2 → (1,1) next cycle; `ready` returns after 3 cycles; no `done`; `seq_count` unchanged.
- **Reset mid-P3:** `reset`=0 → (1,1), `ready`=1, `seq_count`=0 after that edge; no `done` follows.
